uart_pkt_rx: RTL and testbench
==============================

Name: uart_pkt_rx

Overview:
Parametrised RS-232 packet receiver that replaces the fixed 8-byte, fixed-baud receiver. It does the following:
- Oversamples the serial line and recovers bytes.
- Frames them into packets delimited by SOF and EOF bytes.
- Checks the stop bit, SOF, EOF and inter-byte timeout.
- Presents each completed packet on a valid/ready interface to the downstream RAM/AES controller.

Also emits a per-byte stream and sticky-free error pulses for status logging.

Parameters:
CLKS_PER_BIT, 47, clk cycles per UART bit (≥4).
PKT_BYTES, 8, bytes per packet including SOF and EOF (≥2).
SOF_BYTE, 8'h02, required first byte.
EOF_BYTE, 8'h03, required last byte.
TIMEOUT_CLKS, 500000, maximum clk cycles from SOF acceptance to EOF before abort.
SYNC_STAGES, 2, rx input synchroniser depth (≥2).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rx_i  in  1  asynchronous serial line, idle high
pkt_valid  out  1  pkt_data holds a complete, checked packet
pkt_ready  in  1  consumer accepts packet when pkt_valid&pkt_ready
pkt_data  out  PKT_BYTES*8  packet; byte k (arrival order) at [8k+7:8k]
byte_valid  out  1  one-cycle pulse, byte_data valid
byte_data  out  8  last received byte
err_frame  out  1  pulse: stop bit sampled low
err_sof  out  1  pulse: first byte ≠ SOF_BYTE
err_eof  out  1  pulse: last byte ≠ EOF_BYTE
err_timeout  out  1  pulse: packet exceeded TIMEOUT_CLKS
err_overrun  out  1  pulse: packet completed while pkt_valid&~pkt_ready
busy  out  1  packet in progress (SOF accepted, not yet finished/aborted)

Behaviour:
- Reset values: all outputs 0; pkt_data 0; FSM in IDLE; all counters 0. rst mid-packet discards the partial packet with no error pulse.
- rx_i passes through SYNC_STAGES flops, reset to 1. Only the synchronised signal rxs is used; all latencies below are relative to rxs.
- Bit FSM: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on rxs (prev 1, now 0) loads the bit timer and enters START.
  - START: waits CLKS_PER_BIT/2 cycles (integer divide), then samples. If rxs=1 it is a false start: return to IDLE, no error. If rxs=0, enter DATA.
  - DATA: samples 8 bits, each CLKS_PER_BIT after the previous sample, LSB first, shifting into a byte register. After the 8th sample, enter STOP.
  - STOP: samples once after CLKS_PER_BIT. If rxs=1, byte_valid pulses on the next cycle with byte_data. If rxs=0, err_frame pulses, the packet is aborted, and the FSM waits in IDLE until rxs=1 before re-arming edge detection.
- Packet layer, with byte index idx 0..PKT_BYTES-1:
  - idx=0, byte≠SOF_BYTE: err_sof pulses, byte is dropped, idx stays 0.
  - idx=0, byte=SOF_BYTE: store it, busy=1, start watchdog.
  - 0<idx<PKT_BYTES-1: store at slot idx, idx++. SOF values inside the packet are data, not resync.
  - idx=PKT_BYTES-1: if byte≠EOF_BYTE, err_eof pulses and the packet is discarded. Otherwise the packet is complete and is handed to the output stage.
  - Error pulses coincide with the byte_valid cycle.
  - On completion or discard: idx=0, busy=0.
- Output stage: a single PKT_BYTES*8 holding register, separate from the assembly buffer.
  - On completion, if pkt_valid=0 or pkt_ready=1 that cycle: load the register and set pkt_valid=1 on the next cycle.
  - Otherwise: err_overrun pulses, the new packet is dropped, and the held packet is unchanged.
  - pkt_valid clears the cycle after pkt_valid&pkt_ready unless a new load occurs in the same cycle.
  - pkt_data is stable while pkt_valid=1.
- Watchdog:
  - Counts every cycle while busy.
  - When the count reaches TIMEOUT_CLKS: err_timeout pulses, the packet is aborted (idx=0, busy=0), and any byte reception in progress is allowed to finish but is treated as idx=0.
  - If timeout and a final byte complete in the same cycle, the timeout wins.
  - Cleared on SOF acceptance.
- Counter widths: $clog2 of each maximum +1; no wrap is possible by construction.

Decomposition:
- Package uart_pkt_pkg holds:
  - The bit FSM state enum (IDLE, START, DATA, STOP).
  - Default SOF/EOF localparams.
  - An error-code enum shared with the TX side.
- One natural sub-module, uart_byte_rx: synchroniser, bit timer and bit FSM, outputting byte_valid, byte_data and err_frame.
- The top level holds the packet assembly, output register and watchdog.

Test Plan:
All scenarios use CLKS_PER_BIT=16, PKT_BYTES=4, TIMEOUT_CLKS=2000.
1. Send 02 A5 3C 03 with pkt_ready=1 -> one pkt_valid, pkt_data=32'h033CA502; four byte_valid pulses; no errors.
2. Send 7F, then 02 11 22 03 -> err_sof once on 7F; then pkt_data=32'h03221102.
3. Send 02 11 22 44 -> err_eof on the 4th byte; pkt_valid stays 0; busy falls.
4. Byte with stop bit forced 0 mid-packet -> err_frame; packet aborted; a following good packet is received correctly once the line returns high.
5. Send 02 11, then idle 2100 cycles -> err_timeout at cycle 2000 after SOF acceptance; busy=0; a following good packet is accepted.
6. pkt_ready=0, send two good packets -> first held unchanged, err_overrun on the second. Then pulse pkt_ready -> pkt_valid drops the next cycle. Also run a 1-cycle low glitch on rx_i -> no byte_valid (false start).

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared types and defaults for the UART packet receiver
// and its transmit counterpart.
package uart_pkt_pkg;

    typedef enum logic [1:0] {
        BIT_IDLE  = 2'd0,
        BIT_START = 2'd1,
        BIT_DATA  = 2'd2,
        BIT_STOP  = 2'd3
    } bit_state_e;

    localparam logic [7:0] DEF_SOF = 8'h02;
    localparam logic [7:0] DEF_EOF = 8'h03;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_FRAME   = 3'd1,
        ERR_SOF     = 3'd2,
        ERR_EOF     = 3'd3,
        ERR_TIMEOUT = 3'd4,
        ERR_OVERRUN = 3'd5
    } err_code_e;

endpackage

// File: rtl/uart_pkt_if.sv
// uart_pkt_if: packet valid/ready handshake between the receiver and
// the downstream RAM/AES controller.
interface uart_pkt_if #(
    parameter int PKT_BYTES = 8
);
    logic                   pkt_valid;
    logic                   pkt_ready;
    logic [PKT_BYTES*8-1:0] pkt_data;

    modport master (
        output pkt_valid,
        output pkt_data,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid,
        input  pkt_data,
        output pkt_ready
    );
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: rx synchroniser, bit timer and bit FSM recovering one
// byte per frame with stop-bit checking.
module uart_byte_rx
    import uart_pkt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 47,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       err_frame
);
    localparam logic [1:0] S_IDLE  = BIT_IDLE;
    localparam logic [1:0] S_START = BIT_START;
    localparam logic [1:0] S_DATA  = BIT_DATA;
    localparam logic [1:0] S_STOP  = BIT_STOP;

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev;
    logic [1:0]             state;
    logic [TW-1:0]          timer;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '1;
            rxs_prev   <= 1'b1;
            state      <= S_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            err_frame  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rxs_prev   <= rxs;
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // a low stop bit leaves rxs_prev low, so no re-arm
                    // happens until the line has been seen high again
                    if (rxs_prev && !rxs) begin
                        state <= S_START;
                        timer <= HALF_M1;
                    end
                end
                S_START: begin
                    if (timer == '0) begin
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            timer   <= BIT_M1;
                            bit_cnt <= '0;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_DATA: begin
                    if (timer == '0) begin
                        shreg <= {rxs, shreg[7:1]};
                        timer <= BIT_M1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_STOP: begin
                    if (timer == '0) begin
                        state <= S_IDLE;
                        if (rxs) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            err_frame <= 1'b1;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx: frames received bytes into SOF/EOF packets with watchdog
// and presents completed packets on a valid/ready holding register.
module uart_pkt_rx
    import uart_pkt_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 47,
    parameter int         PKT_BYTES    = 8,
    parameter logic [7:0] SOF_BYTE     = DEF_SOF,
    parameter logic [7:0] EOF_BYTE     = DEF_EOF,
    parameter int         TIMEOUT_CLKS = 500000,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    uart_pkt_if.master pkt,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       err_frame,
    output logic       err_sof,
    output logic       err_eof,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy
);
    localparam int IW = $clog2(PKT_BYTES) + 1;
    localparam int WW = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [IW-1:0] LAST   = IW'(PKT_BYTES - 1);
    localparam logic [WW-1:0] WD_END = WW'(TIMEOUT_CLKS - 1);

    logic [IW-1:0]               idx_q;
    logic [WW-1:0]               wd_q;
    logic [PKT_BYTES-1:0][7:0]   asm_q;
    logic [PKT_BYTES-1:0][7:0]   pkt_next;
    logic [PKT_BYTES*8-1:0]      hold_q;
    logic                        hold_v;
    logic                        timeout;
    logic                        at_first;
    logic                        at_last;
    logic                        mid_ok;
    logic                        sof_ok;
    logic                        complete;
    logic                        load;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .err_frame (err_frame)
    );

    // a timeout turns the byte landing in the same cycle into a first byte
    assign timeout     = busy && (wd_q == WD_END);
    assign at_first    = timeout || (idx_q == '0);
    assign at_last     = !at_first && (idx_q == LAST);
    assign mid_ok      = byte_valid && !at_first && !at_last;
    assign sof_ok      = byte_valid && at_first && (byte_data == SOF_BYTE);
    assign err_sof     = byte_valid && at_first && (byte_data != SOF_BYTE);
    assign err_eof     = byte_valid && at_last && (byte_data != EOF_BYTE);
    assign complete    = byte_valid && at_last && (byte_data == EOF_BYTE);
    assign load        = complete && (!hold_v || pkt.pkt_ready);
    assign err_overrun = complete && !load;
    assign err_timeout = timeout;

    always_comb begin
        pkt_next              = asm_q;
        pkt_next[PKT_BYTES-1] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            busy   <= 1'b0;
            wd_q   <= '0;
            asm_q  <= '0;
            hold_q <= '0;
            hold_v <= 1'b0;
        end else begin
            if (busy) begin
                wd_q <= wd_q + WW'(1);
            end
            if (err_frame || timeout) begin
                idx_q <= '0;
                busy  <= 1'b0;
            end
            if (sof_ok) begin
                asm_q[0] <= byte_data;
                idx_q    <= IW'(1);
                busy     <= 1'b1;
                wd_q     <= '0;
            end else if (mid_ok) begin
                asm_q[idx_q[IW-2:0]] <= byte_data;
                idx_q                <= idx_q + IW'(1);
            end else if (err_eof || complete) begin
                idx_q <= '0;
                busy  <= 1'b0;
            end
            if (load) begin
                hold_q <= pkt_next;
                hold_v <= 1'b1;
            end else if (pkt.pkt_ready) begin
                hold_v <= 1'b0;
            end
        end
    end

    assign pkt.pkt_valid = hold_v;
    assign pkt.pkt_data  = hold_q;

endmodule

// File: tb/tb_uart_pkt_rx.sv
// tb_uart_pkt_rx: directed serial frames against a packet-level model
// plus hand-computed expectations for each scenario.
module tb_uart_pkt_rx;
    localparam int         CPB = 16;
    localparam int         P   = 4;
    localparam int         TO  = 2000;
    localparam logic [7:0] SOF = 8'h02;
    localparam logic [7:0] EOF = 8'h03;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       rx_i = 1'b1;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       err_frame, err_sof, err_eof;
    logic       err_timeout, err_overrun, busy;

    uart_pkt_if #(.PKT_BYTES(P)) pif ();

    uart_pkt_rx #(
        .CLKS_PER_BIT(CPB),
        .PKT_BYTES   (P),
        .SOF_BYTE    (SOF),
        .EOF_BYTE    (EOF),
        .TIMEOUT_CLKS(TO),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .pkt        (pif),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .err_frame  (err_frame),
        .err_sof    (err_sof),
        .err_eof    (err_eof),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        bit         ok;
    } rec_t;
    rec_t exq[$];

    int             m_idx;
    bit             m_busy;
    bit             m_hv;
    int             m_sof;
    logic [P*8-1:0] m_asm;
    logic [P*8-1:0] m_hd;

    int n_bv = 0, n_sof = 0, n_eof = 0, n_frm = 0;
    int n_to = 0, n_ovr = 0, n_hs = 0;
    int to_delay = -1;
    int t_start  = 0;
    int lat      = -1;

    always @(negedge clk) begin : cmp
        rec_t           r;
        bit             got, exp_to, e_sof, e_eof, e_ovr, comp;
        logic [P*8-1:0] nxt;
        if (rst) begin
            m_idx  = 0;
            m_busy = 0;
            m_hv   = 0;
            m_sof  = 0;
            m_asm  = '0;
            m_hd   = '0;
        end else begin
            n_hs  += int'(pif.pkt_valid && pif.pkt_ready);
            n_bv  += int'(byte_valid);
            n_sof += int'(err_sof);
            n_eof += int'(err_eof);
            n_frm += int'(err_frame);
            n_ovr += int'(err_overrun);
            exp_to = m_busy && (cyc - m_sof == TO);
            chk("busy", busy, m_busy);
            chk("pkt_valid", pif.pkt_valid, m_hv);
            if (m_hv) chk("pkt_data", pif.pkt_data, m_hd);
            chk("err_timeout", err_timeout, exp_to);
            if (err_timeout) begin
                n_to++;
                to_delay = cyc - m_sof;
            end
            if (exp_to) begin
                m_busy = 0;
                m_idx  = 0;
            end
            got = 0; comp = 0;
            e_sof = 0; e_eof = 0; e_ovr = 0;
            if (byte_valid || err_frame) begin
                if (exq.size() == 0) begin
                    chk("spurious_byte", {byte_valid, err_frame}, 0);
                end else begin
                    r   = exq.pop_front();
                    got = 1;
                    chk("byte_valid", byte_valid, r.ok);
                    chk("err_frame", err_frame, !r.ok);
                    if (r.ok) chk("byte_data", byte_data, r.b);
                    if (lat < 0) lat = cyc - t_start;
                end
            end
            if (got && r.ok) begin
                if (m_idx == 0) begin
                    if (r.b != SOF) begin
                        e_sof = 1;
                    end else begin
                        m_asm[7:0] = r.b;
                        m_idx      = 1;
                        m_busy     = 1;
                        m_sof      = cyc;
                    end
                end else if (m_idx < P - 1) begin
                    m_asm[8*m_idx +: 8] = r.b;
                    m_idx++;
                end else begin
                    if (r.b != EOF) e_eof = 1;
                    else comp = 1;
                    m_idx  = 0;
                    m_busy = 0;
                end
            end else if (got) begin
                m_idx  = 0;
                m_busy = 0;
            end
            nxt = m_asm;
            nxt[8*(P-1) +: 8] = r.b;
            if (comp && (!m_hv || pif.pkt_ready)) begin
                m_hv = 1;
                m_hd = nxt;
            end else begin
                if (comp) e_ovr = 1;
                if (pif.pkt_ready) m_hv = 0;
            end
            chk("err_sof", err_sof, e_sof);
            chk("err_eof", err_eof, e_eof);
            chk("err_overrun", err_overrun, e_ovr);
        end
    end

    task automatic bitw(input logic v);
        rx_i = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok = 1);
        rec_t r;
        r.b  = b;
        r.ok = ok;
        exq.push_back(r);
        @(posedge clk);
        #1;
        t_start = cyc;
        bitw(1'b0);
        for (int i = 0; i < 8; i++) bitw(b[i]);
        bitw(ok);
        rx_i = 1'b1;
        if (!ok) begin
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send4(input logic [7:0] a, b, c, d);
        send_byte(a);
        send_byte(b);
        send_byte(c);
        send_byte(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got %0d cycles expected finish", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int b0, h0, e0;
        pif.pkt_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_pkt_valid", pif.pkt_valid, 0);
        chk("rst_pkt_data", pif.pkt_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_errs", {err_frame, err_sof, err_eof,
                         err_timeout, err_overrun}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(20);

        b0 = n_bv; h0 = n_hs; e0 = n_sof + n_eof + n_frm + n_to + n_ovr;
        send4(8'h02, 8'hA5, 8'h3C, 8'h03);
        idle(10);
        chk("s1_data", pif.pkt_data, 32'h033CA502);
        chk("s1_handshakes", n_hs - h0, 1);
        chk("s1_bytes", n_bv - b0, 4);
        chk("s1_latency", lat, 155);
        chk("s1_errs", n_sof + n_eof + n_frm + n_to + n_ovr - e0, 0);

        e0 = n_sof; h0 = n_hs;
        send_byte(8'h7F);
        send4(8'h02, 8'h11, 8'h22, 8'h03);
        idle(10);
        chk("s2_err_sof", n_sof - e0, 1);
        chk("s2_data", pif.pkt_data, 32'h03221102);
        chk("s2_handshakes", n_hs - h0, 1);

        e0 = n_eof; h0 = n_hs;
        send4(8'h02, 8'h11, 8'h22, 8'h44);
        idle(10);
        chk("s3_err_eof", n_eof - e0, 1);
        chk("s3_handshakes", n_hs - h0, 0);
        chk("s3_busy", busy, 0);
        chk("s3_data_kept", pif.pkt_data, 32'h03221102);

        e0 = n_frm; h0 = n_hs;
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h55, 0);
        chk("s4_busy_after_frame", busy, 0);
        send4(8'h02, 8'hAA, 8'hBB, 8'h03);
        idle(10);
        chk("s4_err_frame", n_frm - e0, 1);
        chk("s4_data", pif.pkt_data, 32'h03BBAA02);
        chk("s4_handshakes", n_hs - h0, 1);

        e0 = n_to;
        send_byte(8'h02);
        send_byte(8'h11);
        idle(2100);
        chk("s5_err_timeout", n_to - e0, 1);
        chk("s5_delay", to_delay, 2000);
        chk("s5_busy", busy, 0);
        send4(8'h02, 8'hC3, 8'h5A, 8'h03);
        idle(10);
        chk("s5_data", pif.pkt_data, 32'h035AC302);

        pif.pkt_ready = 1'b0;
        e0 = n_ovr; h0 = n_hs;
        send4(8'h02, 8'h01, 8'h02, 8'h03);
        send4(8'h02, 8'h04, 8'h05, 8'h03);
        idle(10);
        chk("s6_held_data", pif.pkt_data, 32'h03020102);
        chk("s6_err_overrun", n_ovr - e0, 1);
        chk("s6_valid_held", pif.pkt_valid, 1);
        @(posedge clk);
        #1 pif.pkt_ready = 1'b1;
        @(posedge clk);
        #1 pif.pkt_ready = 1'b0;
        @(negedge clk);
        chk("s6_valid_drop", pif.pkt_valid, 0);
        chk("s6_handshakes", n_hs - h0, 1);

        b0 = n_bv; e0 = n_frm;
        @(posedge clk);
        #1 rx_i = 1'b0;
        @(posedge clk);
        #1 rx_i = 1'b1;
        idle(200);
        chk("glitch_bytes", n_bv - b0, 0);
        chk("glitch_frame", n_frm - e0, 0);
        chk("queue_drained", exq.size(), 0);

        pif.pkt_ready = 1'b1;
        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
